ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit that reads the architectural PC register and writes it back. It presents the current PC to instruction memory over a valid/ready request channel and captures the 32-bit response. It hands the (pc, inst) pair to decode over a valid/ready channel, then writes the next PC into the PC register through its write-enable/write-data port. It sits between the PC register, the instruction memory port, and the decode stage; execute feeds it branch/jump redirects.

## Interface
- XLEN, 64, PC and address width
- ILEN, 32, instruction width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pc  in  XLEN  current PC register value (reset value 0x8000_0000, owned by the PC register)
- pc_wen  out  1  PC register write enable, combinational, one-cycle pulse
- pc_wdata  out  XLEN  next PC value
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  XLEN  redirect target
- imem_req_valid / imem_req_ready  out / in  1  request handshake
- imem_req_addr  out  XLEN  fetch address, equal to pc
- imem_resp_valid  in  1  response strobe, no backpressure
- imem_resp_data  in  ILEN  fetched instruction
- imem_resp_err  in  1  access fault
- out_valid / out_ready  out / in  1  decode handshake
- out_pc  out  XLEN  PC of delivered instruction
- out_inst  out  ILEN  instruction, 0 on fault
- out_fault  out  1  misaligned PC or access fault

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, plus a `drop` flag.
- IDLE → REQ unconditionally; IDLE exists only for the first cycle after reset.
- REQ, pc[1:0]≠0: issue no request. Load out_pc=pc, out_inst=0, out_fault=1, then go to HOLD.
- REQ, aligned: imem_req_valid=1 and imem_req_addr=pc. On ready, go to WAIT.
- WAIT: on imem_resp_valid, register out_pc, out_inst=resp_data (0 if err) and out_fault=resp_err, then go to HOLD. If `drop` is set, discard the response, clear `drop`, and go to REQ.
- HOLD: out_valid=1 and outputs stable until out_ready. On the handshake, pc_wen=1 and pc_wdata=pc+4 (mod 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC wraps to 0). Go to REQ.
- Redirect has priority over pc+4 in every state. Effects by state:
  - In all states: pc_wen=1, pc_wdata=redirect_pc.
  - REQ: a request that is not yet accepted is withdrawn (valid drops next cycle). A request accepted in the same cycle goes to WAIT with `drop` set.
  - WAIT: set `drop`.
  - HOLD: out_valid deasserts next cycle, then go to REQ. If out_ready is high in the same cycle, the instruction counts as consumed, but the PC still takes redirect_pc.
- imem_resp_valid outside WAIT is ignored.
- Fault delivery does not stall; decode/trap logic handles out_fault.

## Timing
- Reset values: state=IDLE, drop=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0, imem_req_valid=0, pc_wen=0.
- Reset mid-operation abandons any transaction. Instruction memory is reset with the same reset.
- Best-case latency: request accepted cycle N, response N+1, out_valid N+2, handshake N+2 with pc_wen, next request N+3. That is 3 cycles per instruction.
- The PC register captures pc_wdata at the pc_wen edge. The next REQ therefore sees the new pc.
- Outputs on the decode channel are registered. imem_req_* and pc_w* are combinational from state and inputs.

## Structure
- Package ifu_pkg holds:
  - the state enum;
  - PC_RESET = 64'h8000_0000, shared with the PC register;
  - INST_BYTES = 4;
  - the XLEN/ILEN constants.
- Single module with one FSM and the output register. No sub-module.

## Test plan
- Reset release with pc=0x8000_0000, ready=1, response one cycle later with 0x00000013 → out_valid on cycle 3 with out_pc=0x8000_0000, out_inst=0x13; on handshake pc_wen=1, pc_wdata=0x8000_0004.
- out_ready held low 5 cycles in HOLD → outputs stable, pc_wen=0, no new request; pc_wen fires on the cycle ready rises.
- Redirect to 0x8000_0100 while in WAIT; response 0xDEADBEEF arrives → response discarded, out_valid never asserted for it, next request addr=0x8000_0100.
- pc=0x8000_0002 → no imem request; out_fault=1, out_inst=0. Separately, imem_resp_err=1 → out_fault=1, out_inst=0.
- pc=0xFFFF_FFFF_FFFF_FFFC handshake → pc_wdata=0.
- Redirect together with out handshake in HOLD → pc_wdata=redirect_pc. Reset asserted in WAIT → all outputs at reset values next cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared fetch-unit types and constants.
// Holds the FSM state enum, XLEN/ILEN, the PC reset value and INST_BYTES.
package ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int INST_BYTES = 4;

  // Also used by the architectural PC register.
  localparam logic [XLEN-1:0] PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: PC read/write, imem request/response, decode channel.
// master = fetch unit side, slave = environment (PC reg, imem, decode, exec).
interface ifu_fetch_if;
  import ifu_pkg::*;

  logic [XLEN-1:0] pc;
  logic            pc_wen;
  logic [XLEN-1:0] pc_wdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            imem_resp_err;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            out_fault;

  modport master (
    input  pc,
    output pc_wen,
    output pc_wdata,
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  imem_resp_err,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output out_fault
  );

  modport slave (
    output pc,
    input  pc_wen,
    input  pc_wdata,
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output imem_resp_err,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  out_fault
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC -> imem request -> response -> decode, then PC write.
// Ports: clock, reset (sync, active-high), bus (ifu_fetch_if.master).
module ifu_fetch
  import ifu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  ifu_fetch_if.master bus
);

  state_e          r_state;
  state_e          w_next;
  logic            r_drop;
  logic            w_drop;
  logic            r_out_valid;
  logic            w_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [ILEN-1:0] r_out_inst;
  logic            r_out_fault;

  logic            w_load;
  logic [ILEN-1:0] w_inst;
  logic            w_fault;
  logic            w_misal;
  logic            w_req_valid;
  logic            w_pc_wen;
  logic [XLEN-1:0] w_pc_wdata;
  logic [XLEN-1:0] w_pc_inc;

  assign w_misal  = bus.pc[1:0] != 2'b00;
  assign w_pc_inc = bus.pc + XLEN'(INST_BYTES);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_out_fault <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drop      <= w_drop;
      r_out_valid <= w_out_valid;
      if (w_load) begin
        r_out_pc    <= bus.pc;
        r_out_inst  <= w_inst;
        r_out_fault <= w_fault;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_drop      = r_drop;
    w_out_valid = r_out_valid;
    w_load      = 1'b0;
    w_inst      = '0;
    w_fault     = 1'b0;
    w_req_valid = 1'b0;
    w_pc_wen    = 1'b0;
    w_pc_wdata  = w_pc_inc;

    unique case (r_state)
      S_IDLE: begin
        w_next = S_REQ;
      end
      S_REQ: begin
        if (w_misal) begin
          // A redirect replaces the faulting PC, so no fault is reported.
          if (!bus.redirect_valid) begin
            w_load      = 1'b1;
            w_fault     = 1'b1;
            w_out_valid = 1'b1;
            w_next      = S_HOLD;
          end
        end else begin
          // Unaccepted request under redirect simply retries next cycle
          // with the new PC.
          w_req_valid = 1'b1;
          if (bus.imem_req_ready) begin
            w_next = S_WAIT;
            w_drop = bus.redirect_valid;
          end
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          if (r_drop || bus.redirect_valid) begin
            w_drop = 1'b0;
            w_next = S_REQ;
          end else begin
            w_load      = 1'b1;
            w_inst      = bus.imem_resp_err ? '0 : bus.imem_resp_data;
            w_fault     = bus.imem_resp_err;
            w_out_valid = 1'b1;
            w_next      = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          w_drop = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready || bus.redirect_valid) begin
          w_out_valid = 1'b0;
          w_next      = S_REQ;
        end
        if (bus.out_ready) begin
          w_pc_wen = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (bus.redirect_valid) begin
      w_pc_wen   = 1'b1;
      w_pc_wdata = bus.redirect_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid & ~reset;
  assign bus.imem_req_addr  = bus.pc;
  assign bus.pc_wen         = w_pc_wen & ~reset;
  assign bus.pc_wdata       = w_pc_wdata;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_pc         = r_out_pc;
  assign bus.out_inst       = r_out_inst;
  assign bus.out_fault      = r_out_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch with a PC register model and a
// scoreboard of expected decode-channel transfers.
module tb_ifu_fetch;
  import ifu_pkg::*;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            fault;
  } exp_t;

  logic clk;
  logic rst;
  logic [XLEN-1:0] r_pc;
  int checks;
  int errors;
  exp_t sb[$];
  exp_t m_e;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) r_pc <= PC_RESET;
    else if (bus.pc_wen) r_pc <= bus.pc_wdata;
  end
  assign bus.pc = r_pc;

  // Scoreboard: pop on each decode handshake, sampled before the edge.
  always begin
    @(negedge clk);
    #3;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h inst=%h", bus.out_pc,
                 bus.out_inst);
      end else begin
        m_e = sb.pop_front();
        if (bus.out_pc !== m_e.pc || bus.out_inst !== m_e.inst ||
            bus.out_fault !== m_e.fault) begin
          errors++;
          $display("FAIL sb_pair got pc=%h inst=%h f=%b exp pc=%h inst=%h f=%b",
                   bus.out_pc, bus.out_inst, bus.out_fault,
                   m_e.pc, m_e.inst, m_e.fault);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst,
                      input logic fault);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.imem_resp_err = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 ||
        bus.out_inst !== '0 || bus.out_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got v=%b pc=%h i=%h f=%b exp 0",
               bus.out_valid, bus.out_pc, bus.out_inst, bus.out_fault);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.pc_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got rv=%b wen=%b exp 0 0",
               bus.imem_req_valid, bus.pc_wen);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step();
    checks++;
    if (bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 64'h8000_0000 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_req got rv=%b a=%h ov=%b exp 1 80000000 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.out_valid);
    end
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait got ov=%b rv=%b exp 0 0",
               bus.out_valid, bus.imem_req_valid);
    end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0000_0013;
    push(64'h8000_0000, 32'h0000_0013, 1'b0);
    step();
    bus.imem_resp_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0000 ||
        bus.out_inst !== 32'h13) begin
      errors++;
      $display("FAIL basic_out got v=%b pc=%h i=%h exp 1 80000000 13",
               bus.out_valid, bus.out_pc, bus.out_inst);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0004) begin
      errors++;
      $display("FAIL basic_wen got wen=%b wd=%h exp 1 80000004",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 64'h8000_0004 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_next got rv=%b a=%h ov=%b exp 1 80000004 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0010_0093;
    push(64'h8000_0004, 32'h0010_0093, 1'b0);
    step();
    bus.imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0004 ||
          bus.out_inst !== 32'h0010_0093 || bus.pc_wen !== 1'b0 ||
          bus.imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b pc=%h i=%h wen=%b rv=%b", i,
                 bus.out_valid, bus.out_pc, bus.out_inst, bus.pc_wen,
                 bus.imem_req_valid);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0008) begin
      errors++;
      $display("FAIL bp_wen got wen=%b wd=%h exp 1 80000008",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0100;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0100) begin
      errors++;
      $display("FAIL rw_wen got wen=%b wd=%h exp 1 80000100",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_still_wait got rv=%b ov=%b exp 0 0",
               bus.imem_req_valid, bus.out_valid);
    end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hDEAD_BEEF;
    step();
    bus.imem_resp_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 64'h8000_0100) begin
      errors++;
      $display("FAIL rw_drop got ov=%b rv=%b a=%h exp 0 1 80000100",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0000_0297;
    push(64'h8000_0100, 32'h0000_0297, 1'b0);
    step();
    bus.imem_resp_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0104) begin
      errors++;
      $display("FAIL rw_next got wen=%b wd=%h exp 1 80000104",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0002;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0002) begin
      errors++;
      $display("FAIL mis_wen got wen=%b wd=%h exp 1 80000002",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_noreq got rv=%b exp 0", bus.imem_req_valid);
    end
    push(64'h8000_0002, 32'h0, 1'b1);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_fault !== 1'b1 ||
        bus.out_inst !== 32'h0 || bus.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_out got v=%b f=%b i=%h rv=%b exp 1 1 0 0",
               bus.out_valid, bus.out_fault, bus.out_inst,
               bus.imem_req_valid);
    end
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0200;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0200) begin
      errors++;
      $display("FAIL hold_redir got wen=%b wd=%h exp 1 80000200",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 64'h8000_0200) begin
      errors++;
      $display("FAIL hold_redir_next got ov=%b rv=%b a=%h exp 0 1 80000200",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_access_fault();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h1234_5678;
    bus.imem_resp_err = 1'b1;
    push(64'h8000_0200, 32'h0, 1'b1);
    step();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_fault !== 1'b1 ||
        bus.out_inst !== 32'h0) begin
      errors++;
      $display("FAIL err_out got v=%b f=%b i=%h exp 1 1 0",
               bus.out_valid, bus.out_fault, bus.out_inst);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h8000_0204) begin
      errors++;
      $display("FAIL err_wen got wen=%b wd=%h exp 1 80000204",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    // Redirect lands in the same cycle the request is accepted.
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.pc_wen !== 1'b1 ||
        bus.pc_wdata !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_redir got rv=%b wen=%b wd=%h",
               bus.imem_req_valid, bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hAAAA_AAAA;
    step();
    bus.imem_resp_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_drop got ov=%b rv=%b a=%h exp 0 1 fffffffffffffffc",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h1111_1111;
    push(64'hFFFF_FFFF_FFFF_FFFC, 32'h1111_1111, 1'b0);
    step();
    bus.imem_resp_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.pc_wen !== 1'b1 || bus.pc_wdata !== 64'h0) begin
      errors++;
      $display("FAIL wrap_wdata got wen=%b wd=%h exp 1 0",
               bus.pc_wen, bus.pc_wdata);
    end
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h0) begin
      errors++;
      $display("FAIL wrap_next got rv=%b a=%h exp 1 0",
               bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 ||
        bus.out_inst !== '0 || bus.out_fault !== 1'b0 ||
        bus.imem_req_valid !== 1'b0 || bus.pc_wen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got v=%b pc=%h i=%h f=%b rv=%b wen=%b exp 0",
               bus.out_valid, bus.out_pc, bus.out_inst, bus.out_fault,
               bus.imem_req_valid, bus.pc_wen);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL rst_mid_req got rv=%b a=%h exp 1 80000000",
               bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_pc;
    logic [ILEN-1:0] d;
    exp_pc = 64'h8000_0000;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc) begin
        errors++;
        $display("FAIL b2b_req[%0d] got rv=%b a=%h exp 1 %h", k,
                 bus.imem_req_valid, bus.imem_req_addr, exp_pc);
      end
      step();
      d = 32'h0000_0013 + 32'(k) * 32'h80;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data = d;
      push(exp_pc, d, 1'b0);
      step();
      bus.imem_resp_valid = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.pc_wen !== 1'b1 ||
          bus.pc_wdata !== exp_pc + 64'd4) begin
        errors++;
        $display("FAIL b2b_hs[%0d] got ov=%b wen=%b wd=%h exp 1 1 %h", k,
                 bus.out_valid, bus.pc_wen, bus.pc_wdata, exp_pc + 64'd4);
      end
      exp_pc = exp_pc + 64'd4;
      step();
    end
    bus.imem_req_ready = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_misaligned();
    test_access_fault();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
